brick_map: RTL
==============

BRICK_MAP -- requirements
Module: brick_map

Interface
REQ-001 SHALL have parameter BLOCK_SPACING_X, default 40, meaning horizontal gap and left margin in pixels.
REQ-002 SHALL have parameter BLOCK_SPACING_Y, default 20, meaning vertical gap between rows in pixels.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 80, meaning brick width in pixels.
REQ-004 SHALL have parameter BLOCK_HEIGHT, default 30, meaning brick height in pixels.
REQ-005 SHALL have parameter TOP_Y, default 40, meaning first-row top edge in pixels.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port restart, input, 1 bit, one-cycle request to reload all bricks.
REQ-009 SHALL have port erase_enable, input, 1 bit, erase request from the ball block, level-held, possibly multi-cycle.
REQ-010 SHALL have port e_pos, input, 6 bits, index of the brick to erase.
REQ-011 SHALL have port pixel_x, input, 10 bits, renderer query column.
REQ-012 SHALL have port pixel_y, input, 10 bits, renderer query row.
REQ-013 SHALL have port brick_on, output, 1 bit, queried pixel lies inside an active brick.
REQ-014 SHALL have port brick_idx, output, 4 bits, index of the brick hit by the query; 15 when none.
REQ-015 SHALL have port active_mask, output, 12 bits, bit i set means brick i present.
REQ-016 SHALL have port bricks_left, output, 4 bits, population count of active_mask.
REQ-017 SHALL have port score, output, 8 bits, bricks destroyed since reset, saturating at 255.
REQ-018 SHALL have port erase_ack, output, 1 bit, one-cycle pulse when an erase is committed.
REQ-019 SHALL have port erase_err, output, 1 bit, one-cycle pulse when an erase is rejected.
REQ-020 SHALL have port win, output, 1 bit, all bricks cleared.

Function
REQ-021 Layout SHALL be fixed: brick i<5 at col i row 0; 5<=i<10 at col i-5 row 1; brick 10 at col 1 row 2; brick 11 at col 3 row 2.
REQ-022 Brick at col c row r SHALL span x in [40+120c, 40+120c+79] and y in [TOP_Y+50r, TOP_Y+50r+29], computed from parameters, inclusive bounds.
REQ-023 An erase event SHALL be the rising edge of erase_enable, via a registered previous value; a held-high request counts once.
REQ-024 FSM states SHALL be IDLE, COMMIT, WIN; reset state IDLE.
REQ-025 IDLE: an erase event SHALL latch e_pos and go to COMMIT next cycle.
REQ-026 COMMIT: if latched index <12 and its bit is set, SHALL clear the bit, increment score (saturating), and pulse erase_ack.
REQ-027 COMMIT: otherwise (index >=12 or brick already cleared), SHALL pulse erase_err with no mask or score change.
REQ-028 COMMIT SHALL exit to WIN if the mask becomes zero, else to IDLE; erase_ack or erase_err appears 2 cycles after the input rising edge.
REQ-029 WIN: erase events SHALL be ignored with no ack or err; win SHALL be 1 in WIN only.
REQ-030 restart SHALL load active_mask=12'hFFF, go to IDLE, and drop any pending COMMIT; score SHALL be kept.
REQ-031 restart and an erase event in the same cycle: restart SHALL win and the erase SHALL be discarded.
REQ-032 An erase event arriving while in COMMIT SHALL be dropped; the ball block guarantees spacing of at least 2 cycles.
REQ-033 bricks_left SHALL be registered and track active_mask with 1-cycle lag.
REQ-034 Pixel query SHALL have 1-cycle latency: brick_on/brick_idx reflect the pixel_x/pixel_y and active_mask sampled at the previous edge; brick_on=0 when the brick is cleared.
REQ-035 All comparisons SHALL be unsigned 10-bit with 11-bit intermediates; no wrap on edge sums.

Reset
REQ-036 reset low at a clock edge SHALL set active_mask=12'hFFF, score=0, bricks_left=12, brick_on=0, brick_idx=15, erase_ack=0, erase_err=0, win=0, state=IDLE, previous erase_enable=0.
REQ-037 reset SHALL override restart and erase in the same cycle, including reset mid-COMMIT (no ack issued).

Verification
REQ-038 Reset, then query (45,45) -> brick_on=1, brick_idx=0 one cycle later; query (125,45) -> brick_on=0, brick_idx=15.
REQ-039 erase_enable high 5 cycles, e_pos=3 -> single erase_ack 2 cycles after rise, active_mask=12'hFF7, score=1, bricks_left=11 next cycle.
REQ-040 Repeat erase of e_pos=3 -> erase_err pulse, score stays 1; erase e_pos=40 -> erase_err, mask unchanged.
REQ-041 Erase all 12 indices -> win=1 after the twelfth ack, score=12, then further erase -> no ack/err.
REQ-042 restart coincident with erase rise e_pos=0 -> mask=12'hFFF, no ack, win=0, score preserved.
REQ-043 reset asserted in COMMIT cycle -> no erase_ack, all outputs at reset values next cycle.

Source files
------------

// File: rtl/brick_map_if.sv
// Signal bundle between brick_map and its ball/renderer neighbours.
// The master drives the requests and queries; the slave (brick_map) returns the status.
interface brick_map_if;
   logic        restart;
   logic        erase_enable;
   logic [5:0]  e_pos;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        brick_on;
   logic [3:0]  brick_idx;
   logic [11:0] active_mask;
   logic [3:0]  bricks_left;
   logic [7:0]  score;
   logic        erase_ack;
   logic        erase_err;
   logic        win;

   modport master (
      output restart, erase_enable, e_pos, pixel_x, pixel_y,
      input  brick_on, brick_idx, active_mask, bricks_left, score,
             erase_ack, erase_err, win
   );

   modport slave (
      input  restart, erase_enable, e_pos, pixel_x, pixel_y,
      output brick_on, brick_idx, active_mask, bricks_left, score,
             erase_ack, erase_err, win
   );
endinterface

// File: rtl/brick_map.sv
// Twelve-brick playfield: presence mask, erase commit FSM with score,
// and a registered pixel hit test for the renderer.
module brick_map #(
   parameter int BLOCK_SPACING_X = 40,
   parameter int BLOCK_SPACING_Y = 20,
   parameter int BLOCK_WIDTH     = 80,
   parameter int BLOCK_HEIGHT    = 30,
   parameter int TOP_Y           = 40
) (
   input logic        clk,
   input logic        reset,
   brick_map_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COMMIT, WIN} state_e;

   state_e      state_q, state_d;
   logic        prev_q;
   logic [5:0]  pos_q, pos_d;
   logic [11:0] mask_q, mask_d;
   logic [7:0]  score_q, score_d;
   logic [3:0]  left_q, left_d;
   logic        on_q, on_d;
   logic [3:0]  idx_q, idx_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        erase_event;
   logic [10:0] px, py;

   // Rows 0 and 1 hold five bricks each; row 2 holds two, under columns 1 and 3.
   function automatic int col_of(input int i);
      if (i < 5)       return i;
      else if (i < 10) return i - 5;
      else if (i == 10) return 1;
      else             return 3;
   endfunction

   function automatic int row_of(input int i);
      if (i < 5)       return 0;
      else if (i < 10) return 1;
      else             return 2;
   endfunction

   function automatic logic [10:0] x_lo(input int i);
      return 11'(BLOCK_SPACING_X + col_of(i) * (BLOCK_WIDTH + BLOCK_SPACING_X));
   endfunction

   function automatic logic [10:0] x_hi(input int i);
      return 11'(BLOCK_SPACING_X + col_of(i) * (BLOCK_WIDTH + BLOCK_SPACING_X) + BLOCK_WIDTH - 1);
   endfunction

   function automatic logic [10:0] y_lo(input int i);
      return 11'(TOP_Y + row_of(i) * (BLOCK_HEIGHT + BLOCK_SPACING_Y));
   endfunction

   function automatic logic [10:0] y_hi(input int i);
      return 11'(TOP_Y + row_of(i) * (BLOCK_HEIGHT + BLOCK_SPACING_Y) + BLOCK_HEIGHT - 1);
   endfunction

   assign erase_event = bus.erase_enable & ~prev_q;
   assign px          = {1'b0, bus.pixel_x};
   assign py          = {1'b0, bus.pixel_y};

   always_comb begin
      // NOTE: every target gets a default first, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      pos_d   = pos_q;
      mask_d  = mask_q;
      score_d = score_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      if (bus.restart) begin
         mask_d  = 12'hFFF;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (erase_event) begin
                  pos_d   = bus.e_pos;
                  state_d = COMMIT;
               end
            end
            COMMIT: begin
               if (pos_q < 6'd12 && mask_q[pos_q[3:0]]) begin
                  mask_d[pos_q[3:0]] = 1'b0;
                  score_d            = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                  ack_d              = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = (mask_d == 12'h000) ? WIN : IDLE;
            end
            WIN: state_d = WIN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      on_d   = 1'b0;
      idx_d  = 4'hF;
      left_d = 4'd0;
      for (int i = 0; i < 12; i++) begin
         left_d = left_d + 4'(mask_q[i]);
         if (mask_q[i] && px >= x_lo(i) && px <= x_hi(i) && py >= y_lo(i) && py <= y_hi(i)) begin
            on_d  = 1'b1;
            idx_d = 4'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments; reset is sampled on the clock edge.
      if (!reset) begin
         state_q <= IDLE;
         prev_q  <= 1'b0;
         pos_q   <= 6'd0;
         mask_q  <= 12'hFFF;
         score_q <= 8'd0;
         left_q  <= 4'd12;
         on_q    <= 1'b0;
         idx_q   <= 4'hF;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= bus.erase_enable;
         pos_q   <= pos_d;
         mask_q  <= mask_d;
         score_q <= score_d;
         left_q  <= left_d;
         on_q    <= on_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign bus.active_mask = mask_q;
   assign bus.bricks_left = left_q;
   assign bus.score       = score_q;
   assign bus.brick_on    = on_q;
   assign bus.brick_idx   = idx_q;
   assign bus.erase_ack   = ack_q;
   assign bus.erase_err   = err_q;
   assign bus.win         = (state_q == WIN);

endmodule
